// File: rtl/motor_pwm.sv
// -----------------------------------------------------------------------------
// motor_pwm
//
// PWM generator sitting behind the per-motor PID controller. The signed drive
// reference is clamped to 0..PERIOD, slew-limited once per PWM period and
// applied as the duty of the next period. Soft start (first period at 0 %)
// and a controlled ramp-down on disable are built into the state machine.
//
// Optional build macro: MOTOR_PWM_DEADBAND_EN
//   defined   -> clamped targets in 1..DEADBAND-1 are forced to 0
//   undefined -> DEADBAND has no effect on the datapath
//
// Ports:
//   clk           system clock
//   resetn        synchronous, active-low reset
//   enable        motor run request
//   mot_set       signed 16-bit drive reference (two's complement)
//   pwm_out       PWM drive to the power stage
//   duty          currently applied duty, unsigned, 0..PERIOD
//   period_start  high during the first cycle of each PWM period
//   sat           last sampled mot_set had to be clamped
//   busy          state machine is not IDLE
// -----------------------------------------------------------------------------
module motor_pwm #(
   parameter int PERIOD    = 1000,
   parameter int SLEW_STEP = 16,
   parameter int DEADBAND  = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic [15:0] mot_set,
   output logic        pwm_out,
   output logic [15:0] duty,
   output logic        period_start,
   output logic        sat,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RAMPDOWN
   } state_t;

   localparam logic [15:0]        CNT_LAST = 16'(PERIOD - 1);
   localparam logic signed [16:0] PERIOD_S = 17'(PERIOD);
   localparam logic signed [16:0] STEP_S   = 17'(SLEW_STEP);

   // Out-of-range parameters stop elaboration instead of building a broken PWM.
   if (PERIOD < 2 || PERIOD > 32767 || SLEW_STEP < 1 || DEADBAND < 0) begin : g_bad_param
      $error("motor_pwm: illegal parameter value");
   end

   state_t             state, state_n;
   logic [15:0]        cnt, cnt_n, duty_n;
   logic               sat_n;
   logic               sample;
   logic signed [16:0] set_ext, clamped, target;
   logic               clamp_hit;

   // Move d toward t by at most SLEW_STEP; 17-bit signed so t-d cannot overflow.
   function automatic logic [15:0] slew(input logic [15:0] d, input logic signed [16:0] t);
      logic signed [16:0] d_s;
      logic signed [16:0] diff;
      logic signed [16:0] res;
      d_s  = signed'({1'b0, d});
      diff = t - d_s;
      if (diff > STEP_S)
         res = d_s + STEP_S;
      else if (diff < -STEP_S)
         res = d_s - STEP_S;
      else
         res = t;
      return res[15:0];
   endfunction

   // Clamp the sign-extended reference into 0..PERIOD.
   assign set_ext   = {mot_set[15], mot_set};
   assign clamp_hit = set_ext[16] || (set_ext > PERIOD_S);
   assign clamped   = set_ext[16] ? 17'sd0 : ((set_ext > PERIOD_S) ? PERIOD_S : set_ext);

`ifdef MOTOR_PWM_DEADBAND_EN
   localparam logic signed [16:0] DEADBAND_S = 17'(DEADBAND);
   // Duties too small to overcome static friction are dropped; sat is unaffected.
   assign target = ((clamped > 17'sd0) && (clamped < DEADBAND_S)) ? 17'sd0 : clamped;
`else
   assign target = clamped;
`endif

   assign sample = (cnt == CNT_LAST);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      state_n = state;
      cnt_n   = cnt;
      duty_n  = duty;
      sat_n   = sat;
      case (state)
         IDLE: begin
            cnt_n  = '0;
            duty_n = '0;
            if (enable)
               state_n = RUN;
         end
         RUN: begin
            cnt_n = sample ? 16'd0 : cnt + 16'd1;
            if (sample) begin
               sat_n  = clamp_hit;
               duty_n = slew(duty, target);
               if (!enable)
                  state_n = RAMPDOWN;
            end
         end
         RAMPDOWN: begin
            cnt_n = sample ? 16'd0 : cnt + 16'd1;
            if (sample) begin
               sat_n  = 1'b0;
               duty_n = slew(duty, 17'sd0);
               if (enable)
                  state_n = RUN;
               else if (duty_n == 16'd0)
                  state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            duty_n  = '0;
            sat_n   = 1'b0;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values. The outputs are registered from the next-state values,
   // so pwm_out/period_start/busy always match the registered state, cnt and
   // duty of the same cycle without any combinational output path.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         cnt          <= '0;
         duty         <= '0;
         sat          <= 1'b0;
         busy         <= 1'b0;
         pwm_out      <= 1'b0;
         period_start <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         duty         <= duty_n;
         sat          <= sat_n;
         busy         <= (state_n != IDLE);
         pwm_out      <= (state_n != IDLE) && (cnt_n < duty_n);
         period_start <= (state_n != IDLE) && (cnt_n == 16'd0);
      end
   end

endmodule

// File: tb/tb_motor_pwm.sv
// -----------------------------------------------------------------------------
// tb_motor_pwm
//
// Directed bench for motor_pwm with PERIOD=100, SLEW_STEP=16, DEADBAND=8.
// Inputs change and outputs are sampled on the falling clock edge. Each task
// drives one scenario; expected duties are hand-computed per PWM period.
// -----------------------------------------------------------------------------
module tb_motor_pwm;

   localparam int P = 100;

`ifdef MOTOR_PWM_DEADBAND_EN
   localparam int DB_EXP = 0;
`else
   localparam int DB_EXP = 5;
`endif

   typedef struct {
      logic en;
      int   set;
      int   d;
      logic s;
   } row_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable;
   logic [15:0] mot_set;
   logic        pwm_out;
   logic [15:0] duty;
   logic        period_start;
   logic        sat;
   logic        busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   motor_pwm #(
      .PERIOD   (P),
      .SLEW_STEP(16),
      .DEADBAND (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .mot_set     (mot_set),
      .pwm_out     (pwm_out),
      .duty        (duty),
      .period_start(period_start),
      .sat         (sat),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Observe one full PWM period starting at a falling edge; ends one period later.
   task automatic measure_period(output logic [15:0] d, output int highs, output int starts,
                                 output logic ps0, output logic s, output logic b);
      highs  = 0;
      starts = 0;
      d      = duty;
      ps0    = period_start;
      s      = sat;
      b      = busy;
      for (int i = 0; i < P; i++) begin
         if (pwm_out) highs++;
         if (period_start) starts++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      enable  = 1'b0;
      mot_set = 16'd0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({pwm_out, period_start, sat, busy} !== 4'b0000 || duty !== 16'd0)
         $display("FAIL reset_state: pwm=%b ps=%b sat=%b busy=%b duty=%0d, want all 0",
                  pwm_out, period_start, sat, busy, duty);
      else pass_cnt++;
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      total_cnt++;
      if ({pwm_out, period_start, busy} !== 3'b000 || duty !== 16'd0)
         $display("FAIL idle_hold: pwm=%b ps=%b busy=%b duty=%0d, want all 0",
                  pwm_out, period_start, busy, duty);
      else pass_cnt++;
   endtask

   task automatic test_ramp_up();
      row_t tab [6] = '{'{1, 50, 0, 0}, '{1, 50, 16, 0}, '{1, 50, 32, 0},
                        '{1, 50, 48, 0}, '{1, 50, 50, 0}, '{1, 50, 50, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      enable  = 1'b1;
      mot_set = 16'd50;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b1 || period_start !== 1'b1)
         $display("FAIL start_busy: busy=%b ps=%b, want 1 1", busy, period_start);
      else pass_cnt++;
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         measure_period(d, highs, starts, ps0, s, b);
         total_cnt++;
         if (d !== 16'(tab[i].d) || highs != tab[i].d || starts != 1 || ps0 !== 1'b1 ||
             s !== tab[i].s || b !== 1'b1)
            $display("FAIL ramp_up row %0d: duty=%0d highs=%0d starts=%0d first=%b sat=%b busy=%b; want duty=highs=%0d starts=1 first=1 sat=%b busy=1",
                     i, d, highs, starts, ps0, s, b, tab[i].d, tab[i].s);
         else pass_cnt++;
      end
   endtask

   task automatic test_saturate();
      row_t tab [9] = '{'{1, 300, 50, 0}, '{1, 300, 66, 1}, '{1, 300, 82, 1},
                        '{1, 300, 98, 1}, '{1, 300, 100, 1}, '{1, 50, 100, 1},
                        '{1, 50, 84, 0}, '{1, 50, 68, 0}, '{1, 50, 52, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         measure_period(d, highs, starts, ps0, s, b);
         total_cnt++;
         if (d !== 16'(tab[i].d) || highs != tab[i].d || starts != 1 || ps0 !== 1'b1 ||
             s !== tab[i].s || b !== 1'b1)
            $display("FAIL saturate row %0d: duty=%0d highs=%0d starts=%0d first=%b sat=%b busy=%b; want duty=highs=%0d starts=1 first=1 sat=%b busy=1",
                     i, d, highs, starts, ps0, s, b, tab[i].d, tab[i].s);
         else pass_cnt++;
      end
   endtask

   task automatic test_negative();
      row_t tab [10] = '{'{1, -200, 50, 0}, '{1, -200, 34, 1}, '{1, -200, 18, 1},
                         '{1, -200, 2, 1}, '{1, -32768, 0, 1}, '{1, 32767, 0, 1},
                         '{1, 50, 16, 1}, '{1, 50, 32, 0}, '{1, 50, 48, 0},
                         '{1, 50, 50, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         measure_period(d, highs, starts, ps0, s, b);
         total_cnt++;
         if (d !== 16'(tab[i].d) || highs != tab[i].d || starts != 1 || ps0 !== 1'b1 ||
             s !== tab[i].s || b !== 1'b1)
            $display("FAIL negative row %0d: duty=%0d highs=%0d starts=%0d first=%b sat=%b busy=%b; want duty=highs=%0d starts=1 first=1 sat=%b busy=1",
                     i, d, highs, starts, ps0, s, b, tab[i].d, tab[i].s);
         else pass_cnt++;
      end
   endtask

   task automatic test_rampdown();
      row_t tab [3] = '{'{0, 0, 34, 0}, '{0, 0, 18, 0}, '{0, 0, 2, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      // Current period runs at duty 50; enable drops partway through it.
      mot_set = 16'd0;
      d       = duty;
      highs   = 0;
      for (int i = 0; i < P; i++) begin
         if (i == 30) enable = 1'b0;
         if (pwm_out) highs++;
         @(negedge clk);
      end
      total_cnt++;
      if (d !== 16'd50 || highs != 50)
         $display("FAIL rampdown_cur: duty=%0d highs=%0d, want 50 50", d, highs);
      else pass_cnt++;
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         measure_period(d, highs, starts, ps0, s, b);
         total_cnt++;
         if (d !== 16'(tab[i].d) || highs != tab[i].d || starts != 1 || ps0 !== 1'b1 ||
             s !== tab[i].s || b !== 1'b1)
            $display("FAIL rampdown row %0d: duty=%0d highs=%0d starts=%0d first=%b sat=%b busy=%b; want duty=highs=%0d starts=1 first=1 sat=%b busy=1",
                     i, d, highs, starts, ps0, s, b, tab[i].d, tab[i].s);
         else pass_cnt++;
      end
      total_cnt++;
      if (busy !== 1'b0 || duty !== 16'd0 || pwm_out !== 1'b0)
         $display("FAIL rampdown_idle: busy=%b duty=%0d pwm=%b, want 0 0 0", busy, duty, pwm_out);
      else pass_cnt++;
      measure_period(d, highs, starts, ps0, s, b);
      total_cnt++;
      if (highs != 0 || starts != 0 || b !== 1'b0)
         $display("FAIL idle_quiet: highs=%0d starts=%0d busy=%b, want 0 0 0", highs, starts, b);
      else pass_cnt++;
   endtask

   task automatic test_rampdown_abort();
      row_t tab [11] = '{'{1, 50, 0, 0}, '{1, 50, 16, 0}, '{1, 50, 32, 0},
                         '{1, 50, 48, 0}, '{0, 0, 50, 0}, '{0, 0, 34, 0},
                         '{1, 40, 18, 0}, '{1, 40, 2, 0}, '{1, 40, 18, 0},
                         '{1, 40, 34, 0}, '{1, 40, 40, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      enable  = 1'b1;
      mot_set = 16'd50;
      @(negedge clk);
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         measure_period(d, highs, starts, ps0, s, b);
         total_cnt++;
         if (d !== 16'(tab[i].d) || highs != tab[i].d || starts != 1 || ps0 !== 1'b1 ||
             s !== tab[i].s || b !== 1'b1)
            $display("FAIL abort row %0d: duty=%0d highs=%0d starts=%0d first=%b sat=%b busy=%b; want duty=highs=%0d starts=1 first=1 sat=%b busy=1",
                     i, d, highs, starts, ps0, s, b, tab[i].d, tab[i].s);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      row_t tab [4] = '{'{1, 80, 40, 0}, '{1, 80, 56, 0}, '{1, 80, 72, 0}, '{1, 80, 80, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         if (i < 3) begin
            measure_period(d, highs, starts, ps0, s, b);
         end else begin
            d = duty;
            repeat (20) @(negedge clk);
            highs = 20;
            if (pwm_out !== 1'b1) highs = -1;
         end
         total_cnt++;
         if (d !== 16'(tab[i].d) || (i < 3 && highs != tab[i].d) || highs < 0)
            $display("FAIL reset_mid_pre row %0d: duty=%0d highs=%0d, want duty=%0d pwm active",
                     i, d, highs, tab[i].d);
         else pass_cnt++;
      end
      resetn = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      total_cnt++;
      if (pwm_out !== 1'b0 || duty !== 16'd0 || busy !== 1'b0 || sat !== 1'b0 || period_start !== 1'b0)
         $display("FAIL reset_mid: pwm=%b duty=%0d busy=%b sat=%b ps=%b, want all 0",
                  pwm_out, duty, busy, sat, period_start);
      else pass_cnt++;
   endtask

   task automatic test_deadband();
      row_t tab [3] = '{'{1, 5, 0, 0}, '{1, 5, DB_EXP, 0}, '{1, 5, DB_EXP, 0}};
      logic [15:0] d;
      int          highs, starts;
      logic        ps0, s, b;
      enable  = 1'b1;
      mot_set = 16'd5;
      @(negedge clk);
      foreach (tab[i]) begin
         enable  = tab[i].en;
         mot_set = 16'(tab[i].set);
         measure_period(d, highs, starts, ps0, s, b);
         total_cnt++;
         if (d !== 16'(tab[i].d) || highs != tab[i].d || starts != 1 || ps0 !== 1'b1 ||
             s !== tab[i].s || b !== 1'b1)
            $display("FAIL deadband row %0d: duty=%0d highs=%0d starts=%0d first=%b sat=%b busy=%b; want duty=highs=%0d starts=1 first=1 sat=%b busy=1",
                     i, d, highs, starts, ps0, s, b, tab[i].d, tab[i].s);
         else pass_cnt++;
      end
      enable = 1'b0;
   endtask

   initial begin
      resetn  = 1'b0;
      enable  = 1'b0;
      mot_set = 16'd0;
      @(negedge clk);
      test_reset();
      test_ramp_up();
      test_saturate();
      test_negative();
      test_rampdown();
      test_rampdown_abort();
      test_reset_mid();
      test_deadband();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
